control_sequencer: RTL



---
 rtl/control_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcode sequencer producing the 16-bit CPU control word
module control_sequencer #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_en,
    input  logic [3:0]  opcode,
    input  logic        carry_flag,
    input  logic        zero_flag,
    output logic [15:0] ctrl_word,
    output logic [2:0]  step,
    output logic        halted
);

    localparam logic [15:0] HLT = 16'h8000;
    localparam logic [15:0] MI  = 16'h4000;
    localparam logic [15:0] RI  = 16'h2000;
    localparam logic [15:0] RO  = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800;
    localparam logic [15:0] II  = 16'h0400;
    localparam logic [15:0] AI  = 16'h0200;
    localparam logic [15:0] AO  = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080;
    localparam logic [15:0] SU  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0020;
    localparam logic [15:0] OI  = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008;
    localparam logic [15:0] CO  = 16'h0004;
    localparam logic [15:0] J   = 16'h0002;
    localparam logic [15:0] FI  = 16'h0001;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_t;

    tstate_t     state;
    logic [15:0] cur_word;
    logic [15:0] t3_word;
    logic [15:0] t4_word;

    // Microcode ROM: control word for a given T-state, opcode and flags.
    function automatic logic [15:0] micro_word(input logic [2:0] s, input logic [3:0] op,
                                               input logic c, input logic z);
        logic [15:0] w;
        w = 16'h0000;
        if (s == 3'd0) begin
            w = CO | MI;
        end else if (s == 3'd1) begin
            w = RO | II | CE;
        end else begin
            case (op)
                4'b0001: w = (s == 3'd2) ? (IO | MI) : (s == 3'd3) ? (RO | AI) : 16'h0000;
                4'b0010: w = (s == 3'd2) ? (IO | MI) : (s == 3'd3) ? (RO | BI) :
                             (s == 3'd4) ? (EO | AI | FI) : 16'h0000;
                4'b0011: w = (s == 3'd2) ? (IO | MI) : (s == 3'd3) ? (RO | BI) :
                             (s == 3'd4) ? (EO | AI | SU | FI) : 16'h0000;
                4'b0100: w = (s == 3'd2) ? (IO | MI) : (s == 3'd3) ? (AO | RI) : 16'h0000;
                4'b0101: w = (s == 3'd2) ? (IO | AI) : 16'h0000;
                4'b0110: w = (s == 3'd2) ? (IO | J) : 16'h0000;
                4'b0111: w = (s == 3'd2 && c) ? (IO | J) : 16'h0000;
                4'b1000: w = (s == 3'd2 && z) ? (IO | J) : 16'h0000;
                4'b1110: w = (s == 3'd2) ? (AO | OI) : 16'h0000;
                4'b1111: w = (s == 3'd2) ? HLT : 16'h0000;
                4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101:
                    w = (s == 3'd2 && HALT_ON_ILLEGAL) ? HLT : 16'h0000;
                default: w = 16'h0000;
            endcase
        end
        return w;
    endfunction

    // Current word plus lookahead words used to skip empty trailing T-states.
    always_comb begin
        cur_word = micro_word(state, opcode, carry_flag, zero_flag);
        t3_word  = micro_word(3'd3, opcode, carry_flag, zero_flag);
        t4_word  = micro_word(3'd4, opcode, carry_flag, zero_flag);
    end

    // Downstream loads are level-qualified each clk, so gate the word to 0 when not advancing.
    always_comb begin
        ctrl_word = 16'h0000;
        if (!rst && step_en && !halted) begin
            ctrl_word = cur_word;
        end
    end

    assign step = state;

    // T-state sequencer with latched halt; T2 is always visited, later states only if non-empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= T0;
            halted <= 1'b0;
        end else if (step_en && !halted) begin
            case (state)
                T0: state <= T1;
                T1: state <= T2;
                T2: begin
                    if (cur_word[15]) begin
                        halted <= 1'b1;
                    end else if (t3_word == 16'h0000) begin
                        state <= T0;
                    end else begin
                        state <= T3;
                    end
                end
                T3: state <= (t4_word == 16'h0000) ? T0 : T4;
                T4: state <= T0;
                default: state <= T0;
            endcase
        end
    end

endmodule
